// File: rtl/raw_linebuf_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : raw_linebuf_sequencer_if
//  Description : Pixel-stream inputs and line-RAM strobe/status outputs of
//                the raw line-buffer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface raw_linebuf_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              sof;
  logic              data_valid;
  logic              wr_en_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              row_odd;
  logic              col_odd;
  logic              row_end;
  logic              frame_done;
  logic              busy;
  logic              err_short;

  modport master (
    output sof, data_valid,
    input  wr_en_a, wr_en_b, wr_addr, rd_en_a, rd_en_b, rd_addr,
    input  rd_valid, row_odd, col_odd, row_end, frame_done, busy, err_short
  );

  modport slave (
    input  sof, data_valid,
    output wr_en_a, wr_en_b, wr_addr, rd_en_a, rd_en_b, rd_addr,
    output rd_valid, row_odd, col_odd, row_end, frame_done, busy, err_short
  );
endinterface
`default_nettype wire

// File: rtl/raw_linebuf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : raw_linebuf_sequencer
//  Description : Column/row sequencer for the ping-pong line RAMs feeding the
//                Bayer-to-RGB datapath; writes one bank, reads the other.
//  Revision    : 1.0 - initial release
// ============================================================================
module raw_linebuf_sequencer #(
  parameter int LINE_W  = 1280,
  parameter int FRAME_H = 1024,
  parameter int ADDR_W  = 11,
  parameter int ROW_W   = 11
) (
  input  wire logic                     clk,
  input  wire logic                     aclr,
  raw_linebuf_sequencer_if.slave        bus
);

  localparam logic [ADDR_W-1:0] c_LAST_COL = ADDR_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0]  c_LAST_ROW = ROW_W'(FRAME_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_wr_sel;      // 0 = bank A written, 1 = bank B written
  logic               r_rd_valid;
  logic               r_row_odd;
  logic               r_col_odd;
  logic               r_row_end;
  logic               r_frame_done;
  logic               r_err_short;

  logic [ADDR_W-1:0]  w_col_eff;
  logic [ROW_W-1:0]   w_row_eff;
  logic               w_sel_eff;
  logic               w_start;
  logic               w_active;
  logic               w_accept;
  logic               w_wrap;
  logic               w_last;
  logic               w_rd_ok;

  // sof restarts the frame in the same cycle, so its pixel is (0,0) in bank A.
  assign w_col_eff = bus.sof ? '0   : r_col;
  assign w_row_eff = bus.sof ? '0   : r_row;
  assign w_sel_eff = bus.sof ? 1'b0 : r_wr_sel;

  assign w_start   = (r_state == ST_IDLE) & (bus.sof | bus.data_valid);
  assign w_active  = (r_state != ST_IDLE) | w_start;
  assign w_accept  = bus.data_valid & w_active;
  assign w_wrap    = w_accept & (w_col_eff == c_LAST_COL);
  assign w_last    = w_wrap & (w_row_eff == c_LAST_ROW);
  assign w_rd_ok   = bus.data_valid & (r_state == ST_RUN) & ~bus.sof;

  assign bus.wr_en_a    = w_accept & ~w_sel_eff;
  assign bus.wr_en_b    = w_accept &  w_sel_eff;
  assign bus.rd_en_a    = w_rd_ok  &  r_wr_sel;
  assign bus.rd_en_b    = w_rd_ok  & ~r_wr_sel;
  assign bus.wr_addr    = w_col_eff;
  assign bus.rd_addr    = w_col_eff;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.row_odd    = r_row_odd;
  assign bus.col_odd    = r_col_odd;
  assign bus.row_end    = r_row_end;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.err_short  = r_err_short;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_wr_sel     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_row_odd    <= 1'b0;
      r_col_odd    <= 1'b0;
      r_row_end    <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
    end else begin
      r_rd_valid   <= w_rd_ok;
      r_row_odd    <= w_rd_ok & r_row[0];
      r_col_odd    <= w_rd_ok & r_col[0];
      r_row_end    <= w_wrap;
      r_frame_done <= w_last;

      if (bus.sof && (r_col != '0)) begin
        r_err_short <= 1'b1;
      end

      if (w_last) begin
        r_state <= ST_IDLE;
      end else if (w_wrap && (w_row_eff == '0)) begin
        r_state <= ST_RUN;
      end else if (bus.sof || w_start) begin
        r_state <= ST_FILL;
      end

      if (w_accept) begin
        r_col <= w_wrap ? '0 : (w_col_eff + ADDR_W'(1));
      end else if (bus.sof) begin
        r_col <= '0;
      end

      // Bank select restarts at A every frame so row 0 always lands in bank A.
      if (w_last) begin
        r_row    <= '0;
        r_wr_sel <= 1'b0;
      end else if (w_wrap) begin
        r_row    <= w_row_eff + ROW_W'(1);
        r_wr_sel <= ~w_sel_eff;
      end else if (bus.sof) begin
        r_row    <= '0;
        r_wr_sel <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raw_linebuf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raw_linebuf_sequencer
//  Description : Scoreboard bench for raw_linebuf_sequencer (LINE_W=4, FRAME_H=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_raw_linebuf_sequencer;
  localparam int LINE_W  = 4;
  localparam int FRAME_H = 3;
  localparam int ADDR_W  = 3;
  localparam int ROW_W   = 2;

  logic clk  = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  raw_linebuf_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  raw_linebuf_sequencer #(
    .LINE_W (LINE_W),
    .FRAME_H(FRAME_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) u_dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  typedef struct packed {
    logic rv;
    logic ro;
    logic co;
    logic re;
    logic fd;
    logic busy;
    logic err;
  } reg_exp_t;

  reg_exp_t q_exp[$];
  int       n_checks = 0;
  int       n_pass   = 0;

  // reference frame position: pixel index within the current frame
  int k_pix    = 0;
  bit m_active = 1'b0;
  bit m_err    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input bit s, input bit dv);
    reg_exp_t    e;
    reg_exp_t    p;
    int          row;
    int          c;
    bit          bank_b;
    bit          rd;
    logic [3:0]  stb;
    @(posedge clk);
    #1;
    bus.sof        = s;
    bus.data_valid = dv;
    if (s) begin
      if ((k_pix % LINE_W) != 0) m_err = 1'b1;
      k_pix    = 0;
      m_active = 1'b1;
    end
    e   = '0;
    stb = 4'b0000;
    row = 0;
    c   = 0;
    if (dv) begin
      if (!m_active) begin
        m_active = 1'b1;
        k_pix    = 0;
      end
      row    = k_pix / LINE_W;
      c      = k_pix % LINE_W;
      bank_b = (row % 2) == 1;
      rd     = row > 0;
      stb    = {!bank_b, bank_b, rd && bank_b, rd && !bank_b};
      e.rv   = rd;
      e.ro   = rd && ((row % 2) == 1);
      e.co   = rd && ((c % 2) == 1);
      e.re   = (c == LINE_W - 1);
      e.fd   = e.re && (row == FRAME_H - 1);
      k_pix++;
      if (e.fd) begin
        m_active = 1'b0;
        k_pix    = 0;
      end
    end
    e.busy = m_active;
    e.err  = m_err;
    @(negedge clk);
    check_val("strobes", 32'({bus.wr_en_a, bus.wr_en_b, bus.rd_en_a, bus.rd_en_b}), 32'(stb));
    if (dv) begin
      check_val("wr_addr", 32'(bus.wr_addr), 32'(c));
      check_val("rd_addr", 32'(bus.rd_addr), 32'(c));
    end
    if (q_exp.size() > 0) begin
      p = q_exp.pop_front();
      check_val("rd_valid", 32'(bus.rd_valid), 32'(p.rv));
      if (p.rv) begin
        check_val("row_odd", 32'(bus.row_odd), 32'(p.ro));
        check_val("col_odd", 32'(bus.col_odd), 32'(p.co));
      end
      check_val("row_end",    32'(bus.row_end),    32'(p.re));
      check_val("frame_done", 32'(bus.frame_done), 32'(p.fd));
      check_val("busy",       32'(bus.busy),       32'(p.busy));
      check_val("err_short",  32'(bus.err_short),  32'(p.err));
    end
    q_exp.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, 32'({bus.wr_en_a, bus.wr_en_b, bus.rd_en_a, bus.rd_en_b,
                        bus.wr_addr, bus.rd_addr, bus.rd_valid, bus.row_odd,
                        bus.col_odd, bus.row_end, bus.frame_done, bus.busy,
                        bus.err_short}), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    aclr           = 1'b0;
    bus.sof        = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    aclr     = 1'b1;
    q_exp.delete();
    k_pix    = 0;
    m_active = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  initial begin
    bus.sof        = 1'b0;
    bus.data_valid = 1'b0;
    #12;
    check_all_zero("initial_reset");
    @(posedge clk);
    #1;
    aclr = 1'b1;

    // back-to-back frame after a lone sof
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1);
    idle(3);

    // one pixel every other cycle
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
    end
    idle(2);

    // free-running frames without sof, second one directly after frame_done
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1);
    idle(2);

    // truncated row: sof at row 1 col 2
    drive(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1);
    idle(2);

    // asynchronous reset during row 2, then a clean frame
    drive(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
    pulse_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1);
    idle(2);

    // sof coincident with the first pixel
    drive(1'b1, 1'b1);
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b1);
    idle(2);

    // random gaps
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
